// File: rtl/aes_pkg.sv
// Shared AES definitions: MixColumns FSM states, column geometry and GF(2^8) helpers.
// Used by the sequential MixColumns engine and its column-mix unit.
package aes_pkg;

    localparam int MC_LAT_DEF = 2;
    localparam int COL_W      = 32;
    localparam int NUM_COLS   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mc_state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] xthree(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

endpackage

// File: rtl/mapcolumn.sv
// MixColumns on one 32-bit column (byte 0 in MSBs), MC_LAT register stages deep.
// Fully pipelined, one column per cycle; no backpressure, caller must accept every result.
module mapcolumn
    import aes_pkg::*;
#(
    parameter int MC_LAT = MC_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [COL_W-1:0] i_col,
    output logic             o_valid,
    output logic [COL_W-1:0] o_col
);

    logic [7:0]       a0, a1, a2, a3;
    logic [COL_W-1:0] mix_d;
    logic [COL_W-1:0] dat_q [MC_LAT];
    logic [MC_LAT-1:0] vld_q;

    assign {a0, a1, a2, a3} = i_col;

    always_comb begin
        mix_d = {xtime(a0)  ^ xthree(a1) ^ a2         ^ a3,
                 a0         ^ xtime(a1)  ^ xthree(a2) ^ a3,
                 a0         ^ a1         ^ xtime(a2)  ^ xthree(a3),
                 xthree(a0) ^ a1         ^ a2         ^ xtime(a3)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MC_LAT; i++) begin
                dat_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            dat_q[0] <= mix_d;
            vld_q[0] <= i_valid;
            for (int i = 1; i < MC_LAT; i++) begin
                dat_q[i] <= dat_q[i-1];
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign o_valid = vld_q[MC_LAT-1];
    assign o_col   = dat_q[MC_LAT-1];

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: one shared column unit, one column per cycle, 7-edge latency (1 on bypass).
// Single state in flight; i_ready only in IDLE, result held in DONE until o_ready.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int MC_LAT = MC_LAT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [127:0] i_state,
    input  logic         i_bypass,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [127:0] o_state
);

    mc_state_e        state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [2:0]       res_cnt_q;
    logic [127:0]     cap_q;
    logic [127:0]     res_q;
    logic             accept;
    logic             mc_in_vld;
    logic [COL_W-1:0] mc_in_col;
    logic             mc_out_vld;
    logic [COL_W-1:0] mc_out_col;

    assign i_ready   = (state_q == IDLE);
    assign o_valid   = (state_q == DONE);
    assign o_state   = res_q;
    assign accept    = i_valid && i_ready;
    assign mc_in_vld = (state_q == ISSUE);
    // Column c lives at bits [127-32c -: 32], i.e. base offset 32*(3-c).
    assign mc_in_col = cap_q[{~col_idx_q, 5'd0} +: COL_W];

    mapcolumn #(
        .MC_LAT (MC_LAT)
    ) u_mapcolumn (
        .clk     (clk),
        .rst     (rst),
        .i_valid (mc_in_vld),
        .i_col   (mc_in_col),
        .o_valid (mc_out_vld),
        .o_col   (mc_out_col)
    );

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    col_idx_d = 2'd0;
                    state_d   = i_bypass ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (col_idx_q == 2'd3) begin
                    col_idx_d = 2'd0;
                    state_d   = DRAIN;
                end else begin
                    col_idx_d = col_idx_q + 2'd1;
                end
            end
            DRAIN: begin
                if (mc_out_vld && (res_cnt_q == 3'd3)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (o_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            col_idx_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
        end
    end

    // Result columns land in issue order, so the counter doubles as the write index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_q     <= '0;
            res_q     <= '0;
            res_cnt_q <= 3'd0;
        end else if (accept) begin
            cap_q     <= i_state;
            res_cnt_q <= 3'd0;
            if (i_bypass) begin
                res_q <= i_state;
            end
        end else if (mc_out_vld) begin
            res_q[{~res_cnt_q[1:0], 5'd0} +: COL_W] <= mc_out_col;
            res_cnt_q <= res_cnt_q + 3'd1;
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: known vectors, bypass, output stall, mid-flight reset, back-to-back.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         i_ready;
    logic [127:0] i_state;
    logic         i_bypass;
    logic         o_valid;
    logic         o_ready;
    logic [127:0] o_state;

    typedef struct {
        logic [127:0] st;
        int           lat;
        int           acc;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         e_new;
    exp_t         cur;
    bit           have_cur = 1'b0;
    logic [127:0] drv_exp = '0;
    int           cyc = 0;
    int           hs_edge = 0;
    bit           have_hs = 1'b0;
    bit           b2b_chk = 1'b0;
    bit           ov_prev = 1'b0;
    int           pulses = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] E1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] E2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] V3 = 128'h01010101_01010101_01010101_01010101;

    mix_columns_seq dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_state  (i_state),
        .i_bypass (i_bypass),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_state  (o_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s);
        logic [127:0] r;
        logic [31:0]  col;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            col = s[127-32*c -: 32];
            {a0, a1, a2, a3} = col;
            r[127-32*c -: 32] = {gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3,
                                 a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3,
                                 a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3),
                                 gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2)};
        end
        return r;
    endfunction

    // Monitor: pushes on acceptance, pops on o_valid rise, checks data, latency and handshake spacing.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            have_cur = 1'b0;
            ov_prev  = 1'b0;
        end else begin
            if (i_valid && i_ready) begin
                e_new.st  = drv_exp;
                e_new.lat = i_bypass ? 1 : 7;
                e_new.acc = cyc + 1;
                exp_q.push_back(e_new);
                if (b2b_chk && have_hs) check("b2b_gap", 128'(cyc + 1), 128'(hs_edge + 1));
            end
            check("rdy_vld_excl", {127'b0, i_ready & o_valid}, 128'b0);
            if (o_valid && !ov_prev) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    check("spurious_ovalid", {127'b0, o_valid}, 128'b0);
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    check("latency", 128'(cyc - cur.acc + 1), 128'(cur.lat));
                end
            end
            if (o_valid && have_cur) check("o_state", o_state, cur.st);
            if (o_valid && o_ready) begin
                hs_edge = cyc + 1;
                have_hs = 1'b1;
            end
            ov_prev = o_valid;
        end
    end

    // Call at posedge+#1; returns at posedge+#1 just after the acceptance edge.
    task automatic send(input logic [127:0] s, input logic byp, input logic [127:0] exp, input bit keep);
        bit ok;
        ok       = 1'b0;
        i_valid  = 1'b1;
        i_state  = s;
        i_bypass = byp;
        drv_exp  = exp;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (i_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) check("accept_timeout", 128'(ok), 128'd1);
        if (!keep) i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !o_valid) done = 1'b1;
        end
        if (!done) check("drain_timeout", 128'(done), 128'd1);
    endtask

    initial begin
        logic [127:0] s;
        logic         byp;
        int           p0;

        rst      = 1'b0;
        i_valid  = 1'b0;
        i_state  = '0;
        i_bypass = 1'b0;
        o_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_o_valid", {127'b0, o_valid}, 128'b0);
        check("rst_o_state", o_state, 128'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("post_rst_i_ready", {127'b0, i_ready}, 128'd1);
        @(posedge clk);
        #1;

        // Known vectors and bypass
        send(V1, 1'b0, E1, 1'b0);
        wait_drain();
        send(V2, 1'b0, E2, 1'b0);
        wait_drain();
        send(V1, 1'b1, V1, 1'b0);
        wait_drain();

        // Output stall held in DONE for 10 cycles
        o_ready = 1'b0;
        send(V2, 1'b0, E2, 1'b0);
        for (int n = 0; n < 50 && !o_valid; n++) @(negedge clk);
        check("stall_reached_done", {127'b0, o_valid}, 128'd1);
        for (int n = 0; n < 10; n++) begin
            check("stall_o_valid", {127'b0, o_valid}, 128'd1);
            check("stall_i_ready", {127'b0, i_ready}, 128'b0);
            check("stall_o_state", o_state, E2);
            @(negedge clk);
        end
        @(posedge clk);
        #1 o_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle_after_hs", {126'b0, i_ready, o_valid}, 128'b10);
        @(posedge clk);
        #1;

        // Reset three edges after acceptance discards the in-flight state
        send(V1, 1'b0, E1, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_o_valid", {127'b0, o_valid}, 128'b0);
        check("midrst_o_state", o_state, 128'b0);
        p0 = pulses;
        @(posedge clk);
        #1 rst = 1'b1;
        send(V3, 1'b0, V3, 1'b0);
        wait_drain();
        repeat (10) @(posedge clk);
        #1;
        check("rst_single_pulse", 128'(pulses - p0), 128'd1);

        // Back-to-back with i_valid held high
        for (int k = 0; k < 6; k++) begin
            s   = {$urandom, $urandom, $urandom, $urandom};
            byp = (k == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            send(s, byp, byp ? s : mix_ref(s), k != 5);
            b2b_chk = 1'b1;
        end
        wait_drain();
        b2b_chk = 1'b0;
        check("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 The block SHALL have parameter MC_LAT, default 2: clock edges from a column entering the column-mix unit to its result appearing.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port i_valid, input, 1 bit: i_state and i_bypass are valid.
REQ-005 The block SHALL have port i_ready, output, 1 bit: the block can accept a state.
REQ-006 The block SHALL have port i_state, input, 128 bits: AES state, column c = bits [127-32c -: 32], byte 0 of each column in its MSBs.
REQ-007 The block SHALL have port i_bypass, input, 1 bit: skip MixColumns (final round), sampled with i_state.
REQ-008 The block SHALL have port o_valid, output, 1 bit: o_state holds a completed result.
REQ-009 The block SHALL have port o_ready, input, 1 bit: the consumer accepts o_state.
REQ-010 The block SHALL have port o_state, output, 128 bits: the MixColumns result (or the bypassed input), same column layout as i_state.

Function
REQ-011 The block SHALL time-share one mapcolumn instance across all four columns of a state, one column per cycle.
REQ-012 The block SHALL accept a state on a rising edge where i_valid and i_ready are both high, capturing i_state and i_bypass into internal registers.
REQ-013 i_ready SHALL be high only in IDLE; only one state SHALL be in flight at a time.
REQ-014 The FSM SHALL have the states IDLE, ISSUE, DRAIN and DONE.
REQ-015 IDLE SHALL go to ISSUE on a non-bypass acceptance, and to DONE on a bypass acceptance.
REQ-016 In ISSUE, a 2-bit column index SHALL drive columns 0,1,2,3 of the captured state on consecutive cycles, 0 to 3 with no wrap; after index 3 the FSM SHALL go to DRAIN.
REQ-017 DRAIN SHALL wait until column 3's result is captured, then go to DONE.
REQ-018 A 3-bit result counter SHALL capture mapcolumn output into result column k exactly MC_LAT edges after column k was issued.
REQ-019 Column-mix latency: o_valid SHALL rise at acceptance edge + 4 + MC_LAT + 1, which is 7 edges with the default MC_LAT.
REQ-020 Bypass latency: o_state SHALL equal the captured i_state unchanged, and o_valid SHALL rise 1 edge after acceptance.
REQ-021 In DONE, o_valid SHALL be high and o_state held stable until o_ready is high on an edge, then the FSM SHALL go to IDLE.
REQ-022 o_ready high while o_valid is low SHALL have no effect.
REQ-023 i_valid high while i_ready is low SHALL not be captured; the source holds its data.
REQ-024 o_valid and i_ready SHALL never both be high in the same cycle.
REQ-025 A new acceptance SHALL be possible in the cycle after the DONE handshake, giving a throughput of 1 state per 8 cycles.
REQ-026 No arithmetic SHALL occur outside mapcolumn; only bytewise GF(2^8) results and 32-bit column concatenation are allowed.

Reset
REQ-027 rst low SHALL immediately force: FSM to IDLE, i_ready=1 (once rst is released), o_valid=0, o_state=0, column index=0, result counter=0, captured state=0.
REQ-028 Reset mid-operation SHALL discard the in-flight state; the first o_valid after reset SHALL belong to a state accepted after reset.
REQ-029 The block SHALL drive rst to the mapcolumn instance unchanged.

Structure
REQ-030 A shared aes_pkg SHALL hold the FSM state enum, the MC_LAT default, and the column width and count constants (32, 4).
REQ-031 mix_columns_seq SHALL contain exactly one sub-module instance: mapcolumn.
REQ-032 The implementation SHALL be 120-400 RTL lines.

Verification
REQ-033 The bench SHALL drive i_state=db135345_f20a225c_01010101_c6c6c6c6, bypass=0, o_ready=1, and require o_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6 with o_valid rising 7 edges after acceptance.
REQ-034 The bench SHALL drive i_state=d4d4d4d5_2d26314c_00000000_ffffffff, bypass=0, and require o_state=d5d5d7d6_4d7ebdf8_00000000_ffffffff.
REQ-035 The bench SHALL drive the REQ-033 input with bypass=1 and require o_state equal to the input, with o_valid 1 edge after acceptance.
REQ-036 The bench SHALL hold o_ready=0 for 10 cycles in DONE and require o_state stable, o_valid=1 and i_ready=0 throughout; when o_ready=1, the FSM returns to IDLE next edge.
REQ-037 The bench SHALL assert rst low at acceptance+3, then accept 01010101 x4, and require exactly one o_valid pulse with o_state=01010101 x4.
REQ-038 The bench SHALL send back-to-back states with i_valid held high and require each acceptance exactly 1 edge after the preceding output handshake, with results in order.
